// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic valid/ready pipeline stage register with DEPTH-entry skid FIFO
module pipe_stage_buf #(
  parameter int DATA_W      = 38,
  parameter int DEPTH       = 2,
  parameter int BUBBLE_ZERO = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_W-1:0]          in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic [PW-1:0]     wr_ptr_nxt;
  logic [PW-1:0]     rd_ptr_nxt;

  // Handshakes depend only on registered count, so ready/valid never chain combinationally.
  assign in_ready_o  = (count < FULL_CNT);
  assign out_valid_o = (count != '0);
  assign count_o     = count;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Explicit wrap so non-power-of-2 depths cycle correctly.
  assign wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
  assign rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);

  always_comb begin
    out_data_o = mem[rd_ptr];
    if ((BUBBLE_ZERO != 0) && (count == '0)) begin
      out_data_o = '0;
    end
  end

  // Storage is cleared on reset so out_data_o reads zero during reset even with BUBBLE_ZERO=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data_i;
        wr_ptr      <= wr_ptr_nxt;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed self-checking bench for pipe_stage_buf at DEPTH=2 and DEPTH=3
module tb_pipe_stage_buf;

  logic clk;
  logic rst;

  logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [37:0] in_data2, out_data2;
  logic [1:0]  count2;

  logic        flush3, in_valid3, in_ready3, out_valid3, out_ready3;
  logic [37:0] in_data3, out_data3;
  logic [1:0]  count3;

  int checks = 0;
  int errors = 0;

  pipe_stage_buf #(.DATA_W(38), .DEPTH(2), .BUBBLE_ZERO(1)) u_d2 (
    .clk(clk), .rst(rst), .flush_i(flush2),
    .in_valid_i(in_valid2), .in_ready_o(in_ready2), .in_data_i(in_data2),
    .out_valid_o(out_valid2), .out_ready_i(out_ready2), .out_data_o(out_data2),
    .count_o(count2)
  );

  pipe_stage_buf #(.DATA_W(38), .DEPTH(3), .BUBBLE_ZERO(1)) u_d3 (
    .clk(clk), .rst(rst), .flush_i(flush3),
    .in_valid_i(in_valid3), .in_ready_o(in_ready3), .in_data_i(in_data3),
    .out_valid_o(out_valid3), .out_ready_i(out_ready3), .out_data_o(out_data3),
    .count_o(count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0;
    in_valid2 = 1'b1; in_data2 = 38'h15; out_ready2 = 1'b0; flush2 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid cyc %0d: got %0b expected 0", c, out_valid2); end
      checks++; if (out_data2 !== 38'h0) begin errors++; $display("FAIL reset_data cyc %0d: got %0h expected 0", c, out_data2); end
      checks++; if (count2 !== 2'd0) begin errors++; $display("FAIL reset_count cyc %0d: got %0d expected 0", c, count2); end
      checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL reset_ready cyc %0d: got %0b expected 1", c, in_ready2); end
    end
    rst = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    checks++; if (out_valid2 !== 1'b1) begin errors++; $display("FAIL first_push_valid: got %0b expected 1", out_valid2); end
    checks++; if (out_data2 !== 38'h15) begin errors++; $display("FAIL first_push_data: got %0h expected 15", out_data2); end
    checks++; if (count2 !== 2'd1) begin errors++; $display("FAIL first_push_count: got %0d expected 1", count2); end
    out_ready2 = 1'b1;
    @(negedge clk);
    checks++; if (count2 !== 2'd0) begin errors++; $display("FAIL first_drain_count: got %0d expected 0", count2); end
  endtask

  task automatic test_streaming();
    out_ready2 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid2 = 1'b1; in_data2 = 38'(i);
      @(negedge clk);
      checks++; if (out_data2 !== 38'(i)) begin errors++; $display("FAIL stream_data %0d: got %0h expected %0h", i, out_data2, i); end
      checks++; if (count2 !== 2'd1) begin errors++; $display("FAIL stream_count %0d: got %0d expected 1", i, count2); end
      checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL stream_ready %0d: got %0b expected 1", i, in_ready2); end
    end
    in_valid2 = 1'b0;
    @(negedge clk);
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL stream_drained: got %0b expected 0", out_valid2); end
  endtask

  task automatic test_backpressure();
    out_ready2 = 1'b0;
    in_valid2 = 1'b1; in_data2 = 38'hA1;
    @(negedge clk);
    checks++; if (count2 !== 2'd1) begin errors++; $display("FAIL bp_count1: got %0d expected 1", count2); end
    in_data2 = 38'hA2;
    @(negedge clk);
    checks++; if (count2 !== 2'd2) begin errors++; $display("FAIL bp_count2: got %0d expected 2", count2); end
    checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %0b expected 0", in_ready2); end
    in_data2 = 38'hA3;
    @(negedge clk);
    checks++; if (count2 !== 2'd2) begin errors++; $display("FAIL bp_held_count: got %0d expected 2", count2); end
    checks++; if (out_data2 !== 38'hA1) begin errors++; $display("FAIL bp_head_a1: got %0h expected a1", out_data2); end
    out_ready2 = 1'b1;
    @(negedge clk);
    checks++; if (out_data2 !== 38'hA2) begin errors++; $display("FAIL bp_head_a2: got %0h expected a2", out_data2); end
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %0b expected 1", in_ready2); end
    checks++; if (count2 !== 2'd1) begin errors++; $display("FAIL bp_count_after_pop: got %0d expected 1", count2); end
    @(negedge clk);
    in_valid2 = 1'b0;
    checks++; if (out_data2 !== 38'hA3) begin errors++; $display("FAIL bp_head_a3: got %0h expected a3", out_data2); end
    @(negedge clk);
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0b expected 0", out_valid2); end
  endtask

  task automatic test_flush();
    out_ready2 = 1'b0;
    in_valid2 = 1'b1; in_data2 = 38'hB1;
    @(negedge clk);
    in_data2 = 38'hB2;
    @(negedge clk);
    checks++; if (count2 !== 2'd2) begin errors++; $display("FAIL flush_fill: got %0d expected 2", count2); end
    flush2 = 1'b1; in_data2 = 38'hB3; out_ready2 = 1'b1;
    @(negedge clk);
    flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
    checks++; if (count2 !== 2'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count2); end
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b expected 0", out_valid2); end
    checks++; if (out_data2 !== 38'h0) begin errors++; $display("FAIL flush_data: got %0h expected 0", out_data2); end
    // one entry held, then flush alongside an accepted push
    in_valid2 = 1'b1; in_data2 = 38'hB1;
    @(negedge clk);
    in_data2 = 38'hB3; flush2 = 1'b1; out_ready2 = 1'b1;
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL flush_push_ready: got %0b expected 1", in_ready2); end
    @(negedge clk);
    flush2 = 1'b0; in_valid2 = 1'b0;
    checks++; if (count2 !== 2'd0) begin errors++; $display("FAIL flush_push_count: got %0d expected 0", count2); end
    @(negedge clk);
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL flush_b3_dropped valid: got %0b expected 0", out_valid2); end
    checks++; if (out_data2 !== 38'h0) begin errors++; $display("FAIL flush_b3_dropped data: got %0h expected 0", out_data2); end
    out_ready2 = 1'b0;
  endtask

  task automatic test_wrap_depth3();
    logic [37:0] q[$];
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    logic iv, ordy, push_m, pop_m;
    flush3 = 1'b0;
    while (popped < 10 && cyc < 300) begin
      checks++; if (count3 !== 2'(q.size())) begin errors++; $display("FAIL wrap_count cyc %0d: got %0d expected %0d", cyc, count3, q.size()); end
      checks++; if (in_ready3 !== (q.size() < 3)) begin errors++; $display("FAIL wrap_ready cyc %0d: got %0b expected %0b", cyc, in_ready3, q.size() < 3); end
      if (q.size() > 0) begin
        checks++; if (out_data3 !== q[0] || out_valid3 !== 1'b1) begin errors++; $display("FAIL wrap_head cyc %0d: got %0b/%0h expected 1/%0h", cyc, out_valid3, out_data3, q[0]); end
      end else begin
        checks++; if (out_valid3 !== 1'b0 || out_data3 !== 38'h0) begin errors++; $display("FAIL wrap_empty cyc %0d: got %0b/%0h expected 0/0", cyc, out_valid3, out_data3); end
      end
      iv   = (pushed < 10) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      in_valid3 = iv; out_ready3 = ordy; in_data3 = 38'h0C0 + 38'(pushed);
      push_m = iv && (q.size() < 3);
      pop_m  = ordy && (q.size() > 0);
      @(posedge clk);
      if (pop_m) begin void'(q.pop_front()); popped++; end
      if (push_m) begin q.push_back(38'h0C0 + 38'(pushed)); pushed++; end
      @(negedge clk);
      cyc++;
    end
    checks++; if (popped != 10) begin errors++; $display("FAIL wrap_timeout: got %0d popped expected 10", popped); end
    in_valid3 = 1'b0; out_ready3 = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready2 = 1'b0;
    in_valid2 = 1'b1; in_data2 = 38'hD1;
    @(negedge clk);
    in_data2 = 38'hD2;
    @(negedge clk);
    in_valid2 = 1'b0;
    checks++; if (count2 !== 2'd2) begin errors++; $display("FAIL areset_pre_count: got %0d expected 2", count2); end
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL areset_valid: got %0b expected 0", out_valid2); end
    checks++; if (count2 !== 2'd0) begin errors++; $display("FAIL areset_count: got %0d expected 0", count2); end
    checks++; if (out_data2 !== 38'h0) begin errors++; $display("FAIL areset_data: got %0h expected 0", out_data2); end
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL areset_ready: got %0b expected 1", in_ready2); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    flush2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
    flush3 = 1'b0; in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_wrap_depth3();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline register for the OpenMIPS stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It is the successor to the fixed single-register stage latches. It adds a valid/ready handshake, a DEPTH-entry skid FIFO, synchronous flush and optional bubble zeroing. A stage can then stall, or be squashed on a branch or exception, without losing or duplicating instructions.

Parameters:
DATA_W, 38, width of the stage payload (default: 32-bit wdata + 5-bit wd + 1-bit wreg).
DEPTH, 2, number of buffer entries; legal range 1..16; non-power-of-2 allowed.
BUBBLE_ZERO, 1, 1 = out_data_o forced to all-zero (NOP) whenever out_valid_o=0; 0 = out_data_o shows the stale head entry.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  reset; asynchronous, active-low.
flush_i  in  1  synchronous squash of all buffered entries.
in_valid_i  in  1  upstream stage presents in_data_i.
in_ready_o  out  1  buffer can accept an entry this cycle.
in_data_i  in  DATA_W  upstream payload.
out_valid_o  out  1  head entry is valid.
out_ready_i  in  1  downstream accepts the head this cycle.
out_data_o  out  DATA_W  head payload.
count_o  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low. While rst=0: count_o=0, out_valid_o=0, out_data_o=0, in_ready_o=1, read/write pointers=0, storage contents don't-care. The first edge after release behaves as normal operation.
- Push = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i. Both are evaluated at the rising edge.
- in_ready_o = (count_o < DEPTH). It is a function of registered state only; there is no combinational path from out_ready_i to in_ready_o.
- out_valid_o = (count_o != 0). out_data_o = storage[rd_ptr], gated to 0 when BUBBLE_ZERO=1 and count_o=0. There is no combinational path from in_* to out_*.
- Latency: an entry pushed at edge t is visible on out_* after edge t. Minimum latency is 1 cycle; there is no bypass when empty.
- Throughput: 1 entry/cycle sustained for DEPTH>=2. DEPTH=1 gives at most 1 entry per 2 cycles when out_ready_i=1 continuously, because a full buffer deasserts in_ready_o.
- Pointers: wr_ptr advances on push, rd_ptr advances on pop. Each wraps from DEPTH-1 to 0 (explicit compare, not a power-of-2 mask).
- Count update:
  - push only: +1
  - pop only: -1
  - push & pop: unchanged, and the data ordering is preserved.
- Full (count=DEPTH): in_ready_o=0, so no push occurs regardless of in_valid_i. A simultaneous pop frees the slot; in_ready_o rises on the following cycle.
- Empty (count=0): a pop cannot occur (out_valid_o=0). A push makes out_valid_o=1 next cycle.
- Flush: when flush_i=1 at an edge, then count_o=0, rd_ptr=wr_ptr=0 and out_valid_o=0 after that edge.
  - A push or pop handshake in the same cycle is discarded; the upstream sees in_ready_o=1 but the entry is dropped by design.
  - Flush has priority over push and pop.
- Reset mid-operation: all entries are lost immediately (async), outputs take their reset values without waiting for a clock edge.
- Order: strict FIFO; no entry is duplicated or reordered.

Test Plan:
1. Reset/idle: hold rst=0 for 3 cycles with in_valid_i=1 and in_data_i=0x15 -> out_valid_o=0, out_data_o=0, count_o=0, in_ready_o=1 throughout. After release, the first push of 0x15 appears on out_data_o one edge later.
2. Streaming, DEPTH=2: push 0x01..0x08 on consecutive cycles with out_ready_i=1 -> out_data_o = 0x01..0x08 each on the cycle after its push, count_o stays 1, in_ready_o never drops.
3. Backpressure/full, DEPTH=2: push 0xA1, 0xA2, 0xA3 with out_ready_i=0 -> count_o=2, in_ready_o=0, and 0xA3 stays held upstream. Then raise out_ready_i for 3 cycles -> outputs 0xA1, 0xA2, 0xA3 in order and in_ready_o reasserts one cycle after the first pop.
4. Flush: fill with 0xB1, 0xB2, then assert flush_i together with push 0xB3 and pop -> next cycle count_o=0 and out_valid_o=0. out_data_o=0 (BUBBLE_ZERO=1), and 0xB3 never appears.
5. Non-power-of-2 wrap, DEPTH=3: push/pop 10 entries in a random valid/ready pattern -> every pointer wraps 2->0 and the output sequence equals the input sequence. The scoreboard checks count_o against a reference model every cycle.
6. Async reset mid-stream: assert rst=0 between clock edges while count_o=2 -> out_valid_o and count_o drop to 0 immediately, without waiting for an edge.
